// File: rtl/router_fsm.sv
// router_fsm
//   Control FSM for a 1-to-3 packet router. It decodes the header address,
//   sequences the header/payload/parity writes into the addressed output FIFO,
//   stalls the source while that FIFO is full or still draining, and returns
//   to address decode when the target FIFO is soft-reset.
//
// Ports
//   clk, rstn              clock, synchronous active-low reset
//   pkt_valid              header/payload bytes present; falls on parity byte
//   data_in[1:0]           header destination address (3 = invalid)
//   fifo_full              full flag of the addressed FIFO
//   fifo_empty_0/1/2       empty flags of output FIFOs
//   soft_rst_0/1/2         read-timeout soft resets of output FIFOs
//   parity_done            parity byte captured by the register block
//   low_pkt_valid          pkt_valid fell while the FIFO was full
//   detect_addr .. busy    Moore decodes of the state register
//   fsm_state[2:0]         current state code
module router_fsm (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_rst_0,
  input  logic       soft_rst_1,
  input  logic       soft_rst_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       write_en_reg,
  output logic       busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_target;
  logic       w_hdr_empty;   // empty flag of the port named on data_in
  logic       w_tgt_empty;   // empty flag of the latched target
  logic       w_tgt_srst;    // soft reset of the latched target

  // Address 3 selects no FIFO: it never looks empty and never soft-resets.
  always_comb begin
    w_hdr_empty = 1'b0;
    case (data_in)
      2'd0:    w_hdr_empty = fifo_empty_0;
      2'd1:    w_hdr_empty = fifo_empty_1;
      2'd2:    w_hdr_empty = fifo_empty_2;
      default: w_hdr_empty = 1'b0;
    endcase
  end

  always_comb begin
    w_tgt_empty = 1'b0;
    w_tgt_srst  = 1'b0;
    case (r_target)
      2'd0:    begin w_tgt_empty = fifo_empty_0; w_tgt_srst = soft_rst_0; end
      2'd1:    begin w_tgt_empty = fifo_empty_1; w_tgt_srst = soft_rst_1; end
      2'd2:    begin w_tgt_empty = fifo_empty_2; w_tgt_srst = soft_rst_2; end
      default: begin w_tgt_empty = 1'b0;         w_tgt_srst = 1'b0;       end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= DECODE_ADDRESS;
      r_target <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS && pkt_valid)
        r_target <= data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_tgt_srst) begin
      w_next = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS:
          if (pkt_valid && data_in != 2'd3)
            w_next = w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:
          w_next = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       w_next = FIFO_FULL_STATE;
          else if (!pkt_valid) w_next = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) w_next = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        w_next = DECODE_ADDRESS;
          else if (low_pkt_valid) w_next = LOAD_PARITY;
          else                    w_next = LOAD_DATA;
        LOAD_PARITY:
          w_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (w_tgt_empty) w_next = LOAD_FIRST_DATA;
        default:
          w_next = DECODE_ADDRESS;
      endcase
    end
  end

  assign detect_addr  = (r_state == DECODE_ADDRESS);
  assign lfd_state    = (r_state == LOAD_FIRST_DATA);
  assign ld_state     = (r_state == LOAD_DATA);
  assign full_state   = (r_state == FIFO_FULL_STATE);
  assign laf_state    = (r_state == LOAD_AFTER_FULL);
  assign rst_int_reg  = (r_state == CHECK_PARITY_ERROR);
  assign write_en_reg = (r_state == LOAD_DATA) || (r_state == LOAD_AFTER_FULL) ||
                        (r_state == LOAD_PARITY);
  // The source may only push in address decode and steady payload load.
  assign busy         = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
  assign fsm_state    = r_state;

endmodule
